// File: rtl/counter_bank_pkg.sv
// Shared types and helpers for the multi-channel counter bank.
package counter_bank_pkg;

  // Counting behaviour applied to every channel of a bank.
  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } mode_t;

  // Widest packed limit vector a bank can carry (16 channels x 32 bits).
  localparam int unsigned MAX_LIMIT_BITS = 512;

  // Default terminal values: every channel counts to its all-ones value.
  // The result is wider than any bank needs; only the low nchan*width bits
  // are ever sliced by the top.
  function automatic logic [MAX_LIMIT_BITS-1:0] default_limit(input int nchan,
                                                             input int width);
    logic [MAX_LIMIT_BITS-1:0] lim;
    lim = '0;
    for (int b = 0; b < MAX_LIMIT_BITS; b++) begin
      if (b < nchan * width) begin
        lim[b] = 1'b1;
      end else begin
        lim[b] = 1'b0;
      end
    end
    return lim;
  endfunction

endpackage

// File: rtl/counter_bank_chan.sv
// One counter channel: clear/load/increment with wrap or saturate, plus a
// combinational carry for the next channel in a cascade.
module counter_bank_chan
  import counter_bank_pkg::*;
#(
  parameter int unsigned       WIDTH     = 8,
  parameter logic [WIDTH-1:0]  LIMIT_VAL = '1,
  parameter mode_t             MODE      = MODE_WRAP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic [WIDTH-1:0] count_o,
  output logic             tc_o,
  output logic             sat_o,
  output logic             tc_next_o,
  output logic             carry_o
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             sat_q, sat_d;
  logic             at_limit_s;

  assign at_limit_s = (count_q == LIMIT_VAL);

  // Carry only leaves a wrapping channel that actually increments past its limit.
  assign carry_o = (MODE == MODE_WRAP) && inc_i && at_limit_s && !clr_i && !load_i;

  // Next-state: clear beats load beats increment beats hold.
  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    if (clr_i) begin
      count_d = '0;
    end else if (load_i) begin
      count_d = (load_val_i > LIMIT_VAL) ? LIMIT_VAL : load_val_i;
    end else if (inc_i) begin
      if (!at_limit_s) begin
        count_d = count_q + ONE;
        tc_d    = (MODE == MODE_SAT) && ((count_q + ONE) == LIMIT_VAL);
      end else if (MODE == MODE_WRAP) begin
        count_d = '0;
        tc_d    = 1'b1;
      end else begin
        count_d = count_q;
        tc_d    = 1'b0;
      end
    end else begin
      count_d = count_q;
    end
    sat_d = (MODE == MODE_SAT) && (count_d == LIMIT_VAL);
  end

  // Channel state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      tc_q    <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      sat_q   <= sat_d;
    end
  end

  assign count_o   = count_q;
  assign tc_o      = tc_q;
  assign sat_o     = sat_q;
  assign tc_next_o = tc_d;

endmodule

// File: rtl/counter_bank.sv
// Bank of NCHAN independent counters with optional carry cascading and a
// registered OR of all terminal-count pulses.
module counter_bank
  import counter_bank_pkg::*;
#(
  parameter int unsigned NCHAN   = 4,
  parameter int unsigned WIDTH   = 8,
  parameter              LIMIT   = default_limit(NCHAN, WIDTH),
  parameter mode_t       MODE    = MODE_WRAP,
  parameter bit          CASCADE = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NCHAN-1:0]       en,
  input  logic [NCHAN-1:0]       clr,
  input  logic [NCHAN-1:0]       load,
  input  logic [NCHAN*WIDTH-1:0] load_val,
  output logic [NCHAN*WIDTH-1:0] count,
  output logic [NCHAN-1:0]       tc,
  output logic [NCHAN-1:0]       sat,
  output logic                   any_tc
);

  logic [NCHAN-1:0] inc_s;
  logic [NCHAN-1:0] carry_s;
  logic [NCHAN-1:0] tc_next_s;
  logic             any_tc_q;
  logic             unused_top_carry_s;

  // The last channel's carry has nowhere to go.
  assign unused_top_carry_s = carry_s[NCHAN-1];

  for (genvar i = 0; i < NCHAN; i++) begin : g_chan
    if (CASCADE && (i > 0)) begin : g_casc
      assign inc_s[i] = en[i] && carry_s[i-1];
    end else begin : g_indep
      assign inc_s[i] = en[i];
    end

    counter_bank_chan #(
      .WIDTH    (WIDTH),
      .LIMIT_VAL(LIMIT[i*WIDTH +: WIDTH]),
      .MODE     (MODE)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .inc_i     (inc_s[i]),
      .clr_i     (clr[i]),
      .load_i    (load[i]),
      .load_val_i(load_val[i*WIDTH +: WIDTH]),
      .count_o   (count[i*WIDTH +: WIDTH]),
      .tc_o      (tc[i]),
      .sat_o     (sat[i]),
      .tc_next_o (tc_next_s[i]),
      .carry_o   (carry_s[i])
    );
  end

  // any_tc is registered from the channels' next tc so it lines up with tc.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      any_tc_q <= 1'b0;
    end else begin
      any_tc_q <= |tc_next_s;
    end
  end

  assign any_tc = any_tc_q;

endmodule

// File: tb/tb_counter_bank.sv
// Directed bench for counter_bank: four bank configurations share one clock
// and reset; expected values are queued on drive and checked after the edge.
module tb_counter_bank;
  import counter_bank_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Wrap bank: 1 x 4 bits, limit 9
  logic        en_w = 1'b0, clr_w = 1'b0, load_w = 1'b0;
  logic [3:0]  lv_w = 4'd0, cnt_w;
  logic        tc_w, sat_w, any_w;
  // Saturate bank: 1 x 4 bits, limit 5
  logic        en_s = 1'b0, clr_s = 1'b0, load_s = 1'b0;
  logic [3:0]  lv_s = 4'd0, cnt_s;
  logic        tc_s, sat_s, any_s;
  // Cascade bank: 3 x 4 bits, limit 9 each
  logic [2:0]  en_c = 3'd0, clr_c = 3'd0, load_c = 3'd0;
  logic [11:0] lv_c = 12'd0, cnt_c;
  logic [2:0]  tc_c, sat_c;
  logic        any_c;
  // Zero-limit bank: 2 x 4 bits, channel 0 limit 0, channel 1 limit 5
  logic [1:0]  en_z = 2'd0, clr_z = 2'd0, load_z = 2'd0;
  logic [7:0]  lv_z = 8'd0, cnt_z;
  logic [1:0]  tc_z, sat_z;
  logic        any_z;

  counter_bank #(.NCHAN(1), .WIDTH(4), .LIMIT(4'd9), .MODE(MODE_WRAP), .CASCADE(1'b0)) u_wrap (
    .clk(clk), .rst(rst), .en(en_w), .clr(clr_w), .load(load_w), .load_val(lv_w),
    .count(cnt_w), .tc(tc_w), .sat(sat_w), .any_tc(any_w));

  counter_bank #(.NCHAN(1), .WIDTH(4), .LIMIT(4'd5), .MODE(MODE_SAT), .CASCADE(1'b0)) u_sat (
    .clk(clk), .rst(rst), .en(en_s), .clr(clr_s), .load(load_s), .load_val(lv_s),
    .count(cnt_s), .tc(tc_s), .sat(sat_s), .any_tc(any_s));

  counter_bank #(.NCHAN(3), .WIDTH(4), .LIMIT({4'd9, 4'd9, 4'd9}), .MODE(MODE_WRAP), .CASCADE(1'b1)) u_casc (
    .clk(clk), .rst(rst), .en(en_c), .clr(clr_c), .load(load_c), .load_val(lv_c),
    .count(cnt_c), .tc(tc_c), .sat(sat_c), .any_tc(any_c));

  counter_bank #(.NCHAN(2), .WIDTH(4), .LIMIT({4'd5, 4'd0}), .MODE(MODE_WRAP), .CASCADE(1'b0)) u_zero (
    .clk(clk), .rst(rst), .en(en_z), .clr(clr_z), .load(load_z), .load_val(lv_z),
    .count(cnt_z), .tc(tc_z), .sat(sat_z), .any_tc(any_z));

  typedef struct {
    string       tag;
    int          sel;
    logic [15:0] exp;
  } item_t;

  item_t sb[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  localparam int W_CNT = 0, W_TC = 1, W_ANY = 2, S_CNT = 3, S_TC = 4, S_SAT = 5;
  localparam int C_CNT = 6, C_TC = 7, C_ANY = 8, Z_CNT = 9, Z_TC = 10, Z_ANY = 11;

  function automatic logic [15:0] obs(input int sel);
    case (sel)
      W_CNT:   return {12'd0, cnt_w};
      W_TC:    return {15'd0, tc_w};
      W_ANY:   return {15'd0, any_w};
      S_CNT:   return {12'd0, cnt_s};
      S_TC:    return {15'd0, tc_s};
      S_SAT:   return {15'd0, sat_s};
      C_CNT:   return {4'd0, cnt_c};
      C_TC:    return {13'd0, tc_c};
      C_ANY:   return {15'd0, any_c};
      Z_CNT:   return {8'd0, cnt_z};
      Z_TC:    return {14'd0, tc_z};
      Z_ANY:   return {15'd0, any_z};
      default: return 16'hxxxx;
    endcase
  endfunction

  task automatic push(input string tag, input int sel, input logic [15:0] e);
    item_t it;
    it.tag = tag;
    it.sel = sel;
    it.exp = e;
    sb.push_back(it);
  endtask

  task automatic check_all();
    item_t       it;
    logic [15:0] o;
    while (sb.size() > 0) begin
      it = sb.pop_front();
      o  = obs(it.sel);
      n_checks++;
      assert (o === it.exp) else begin
        n_fail++;
        $error("FAIL %s observed=%h expected=%h", it.tag, o, it.exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    logic [3:0] d0, d1, d2;
    logic [2:0] etc;

    // Reset held over edges
    @(posedge clk);
    @(posedge clk);
    #1;
    push("rst_w_cnt", W_CNT, 16'd0);
    push("rst_s_sat", S_SAT, 16'd0);
    push("rst_c_cnt", C_CNT, 16'd0);
    push("rst_c_tc", C_TC, 16'd0);
    push("rst_c_any", C_ANY, 16'd0);
    push("rst_z_tc", Z_TC, 16'd0);
    check_all();
    rst = 1'b0;

    // Wrap at 9: 1..9,0,1,2 with tc only on the wrap
    en_w = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      push("wrap_cnt", W_CNT, 16'(k % 10));
      push("wrap_tc", W_TC, {15'd0, (k == 10)});
      push("wrap_any", W_ANY, {15'd0, (k == 10)});
      tick();
    end
    en_w = 1'b0;

    // Saturate at 5: one tc pulse, sat level afterwards
    en_s = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      push("sat_cnt", S_CNT, 16'((k < 5) ? k : 5));
      push("sat_tc", S_TC, {15'd0, (k == 5)});
      push("sat_sat", S_SAT, {15'd0, (k >= 5)});
      tick();
    end
    en_s = 1'b0;

    // Zero limit: count stays 0, tc continuously high
    en_z = 2'b01;
    for (int k = 1; k <= 5; k++) begin
      push("zero_cnt", Z_CNT, 16'd0);
      push("zero_tc", Z_TC, 16'd1);
      push("zero_any", Z_ANY, 16'd1);
      tick();
    end
    en_z = 2'b11;
    push("zero_ch1_cnt", Z_CNT, 16'h0010);
    push("zero_ch1_tc", Z_TC, 16'd1);
    tick();
    en_z = 2'b00;
    push("zero_idle_tc", Z_TC, 16'd0);
    push("zero_idle_any", Z_ANY, 16'd0);
    push("zero_idle_cnt", Z_CNT, 16'h0010);
    tick();

    // Three-digit decimal cascade for 1000 cycles
    en_c = 3'b111;
    for (int k = 1; k <= 1000; k++) begin
      d0  = 4'(k % 10);
      d1  = 4'((k / 10) % 10);
      d2  = 4'((k / 100) % 10);
      etc = {(k % 1000) == 0, (k % 100) == 0, (k % 10) == 0};
      push("casc_cnt", C_CNT, {4'd0, d2, d1, d0});
      push("casc_tc", C_TC, {13'd0, etc});
      push("casc_any", C_ANY, {15'd0, |etc});
      tick();
    end

    // Load clamps to limit
    en_c = 3'b000; load_c = 3'b001; lv_c = {4'd0, 4'd0, 4'd12};
    push("clamp_cnt", C_CNT, 16'h0009);
    push("clamp_tc", C_TC, 16'd0);
    tick();
    // clr beats load
    clr_c = 3'b001; load_c = 3'b001; lv_c = {4'd0, 4'd0, 4'd5};
    push("clr_load_cnt", C_CNT, 16'h0000);
    tick();
    // Load two channels
    clr_c = 3'b000; load_c = 3'b011; lv_c = {4'd0, 4'd3, 4'd9};
    push("load2_cnt", C_CNT, 16'h0039);
    tick();
    // clr on channel 0 kills the carry into channel 1
    load_c = 3'b000; clr_c = 3'b001; en_c = 3'b111;
    push("clr_kill_cnt", C_CNT, 16'h0030);
    push("clr_kill_tc", C_TC, 16'd0);
    tick();
    clr_c = 3'b000; en_c = 3'b000; load_c = 3'b001; lv_c = {4'd0, 4'd0, 4'd9};
    push("reload_cnt", C_CNT, 16'h0039);
    tick();
    // Without clr the carry ripples
    load_c = 3'b000; en_c = 3'b111;
    push("carry_cnt", C_CNT, 16'h0040);
    push("carry_tc", C_TC, 16'd1);
    push("carry_any", C_ANY, 16'd1);
    tick();
    for (int k = 1; k <= 3; k++) begin
      push("pre_rst_cnt", C_CNT, 16'(16'h0040 + k));
      tick();
    end

    // Asynchronous reset mid-count
    rst = 1'b1;
    #1;
    push("async_rst_cnt", C_CNT, 16'd0);
    push("async_rst_tc", C_TC, 16'd0);
    push("async_rst_any", C_ANY, 16'd0);
    push("async_rst_w", W_CNT, 16'd0);
    push("async_rst_sat", S_SAT, 16'd0);
    check_all();
    push("rst_hold_cnt", C_CNT, 16'd0);
    tick();
    rst = 1'b0;
    push("resume_cnt", C_CNT, 16'h0001);
    push("resume_tc", C_TC, 16'd0);
    push("resume_any", C_ANY, 16'd0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
